// File: rtl/manquehuito_loader.sv
// Boot loader: parses HEADER/N/{hi,lo}*N/CHK frames into instruction memory and
// holds manquehuito_domain in reset until a frame with a good checksum has landed.
module manquehuito_loader #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic        clear_i,
  output logic        imem_we_o,
  output logic [7:0]  imem_addr_o,
  output logic [14:0] imem_data_o,
  output logic        cpu_rst_no,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, COUNT, HI, LO, CHECK, RUN, ERROR
  } state_t;

  state_t      state_reg, state_next;
  logic [8:0]  rem_reg, rem_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  csum_reg, csum_next;
  logic [6:0]  hi_reg, hi_next;
  logic [CW-1:0] tmo_reg, tmo_next;
  logic        we_reg, we_next;
  logic [7:0]  addr_reg, addr_next;
  logic [14:0] data_reg, data_next;
  logic [1:0]  code_reg, code_next;
  logic        done_reg, cpu_rst_reg, err_reg;
  logic        accept, in_frame;

  assign rx_ready_o = (state_reg != ERROR);
  assign accept     = rx_valid_i && rx_ready_o;
  assign in_frame   = (state_reg == COUNT) || (state_reg == HI) ||
                      (state_reg == LO) || (state_reg == CHECK);
  assign busy_o     = in_frame;

  assign imem_we_o   = we_reg;
  assign imem_addr_o = addr_reg;
  assign imem_data_o = data_reg;
  assign cpu_rst_no  = cpu_rst_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;
  assign err_code_o  = code_reg;

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    idx_next   = idx_reg;
    csum_next  = csum_reg;
    hi_next    = hi_reg;
    tmo_next   = '0;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;
    code_next  = code_reg;

    if (clear_i) begin
      state_next = IDLE;
      code_next  = 2'b00;
    end else begin
      case (state_reg)
        IDLE: if (accept && rx_data_i == HEADER) state_next = COUNT;
        COUNT: if (accept) begin
          rem_next   = (rx_data_i == 8'd0) ? 9'd256 : {1'b0, rx_data_i};
          idx_next   = 8'd0;
          csum_next  = 8'd0;
          state_next = HI;
        end
        HI: if (accept) begin
          if (rx_data_i[7]) begin
            state_next = ERROR;
            code_next  = 2'b01;
          end else begin
            hi_next    = rx_data_i[6:0];
            csum_next  = csum_reg + rx_data_i;
            state_next = LO;
          end
        end
        LO: if (accept) begin
          csum_next  = csum_reg + rx_data_i;
          rem_next   = rem_reg - 9'd1;
          we_next    = 1'b1;
          addr_next  = idx_reg;
          data_next  = {hi_reg, rx_data_i};
          idx_next   = idx_reg + 8'd1;
          state_next = (rem_reg == 9'd1) ? CHECK : HI;
        end
        CHECK: if (accept) begin
          if (rx_data_i == csum_reg) begin
            state_next = RUN;
          end else begin
            state_next = ERROR;
            code_next  = 2'b10;
          end
        end
        RUN: if (accept && rx_data_i == HEADER) state_next = COUNT;
        default: ;
      endcase

      // An accepted byte always wins over an expiring idle counter.
      if (in_frame && !accept) begin
        if (tmo_reg == TMO_LAST) begin
          state_next = ERROR;
          code_next  = 2'b11;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      idx_reg     <= '0;
      csum_reg    <= '0;
      hi_reg      <= '0;
      tmo_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      code_reg    <= 2'b00;
      done_reg    <= 1'b0;
      cpu_rst_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rem_reg     <= rem_next;
      idx_reg     <= idx_next;
      csum_reg    <= csum_next;
      hi_reg      <= hi_next;
      tmo_reg     <= tmo_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      code_reg    <= code_next;
      // Status flags are decoded from the next state so they are glitch-free flops.
      done_reg    <= (state_next == RUN);
      cpu_rst_reg <= (state_next == RUN);
      err_reg     <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_manquehuito_loader.sv
// Directed bench for manquehuito_loader: frames, error codes, timeout edge, reload and async reset.
module tb_manquehuito_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic        clear_i = 1'b0;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [14:0] imem_data_o;
  logic        cpu_rst_no;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  wr_addr [0:1023];
  logic [14:0] wr_data [0:1023];
  int          wr_n = 0;
  int          base;
  logic [7:0]  sum;

  always #5 clk_i = ~clk_i;

  manquehuito_loader #(.HEADER(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .clear_i(clear_i), .imem_we_o(imem_we_o),
    .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o), .cpu_rst_no(cpu_rst_no),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  // Write monitor: one record per cycle the strobe is high.
  always @(negedge clk_i) begin
    if (imem_we_o) begin
      wr_addr[wr_n] <= imem_addr_o;
      wr_data[wr_n] <= imem_data_o;
      wr_n <= wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    rx_data_i = b;
    rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
  endtask

  initial begin
    #3 rst_ni = 1'b0;
    #1;
    chk("rst_cpu", 32'(cpu_rst_no), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_code", 32'(err_code_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_we", 32'(imem_we_o), 0);
    chk("rst_ready", 32'(rx_ready_o), 1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Valid two-word frame
    base = wr_n;
    send_byte(8'hA5); send_byte(8'h02);
    chk("a_busy", 32'(busy_o), 1);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h02); send_byte(8'h03);
    chk("a_cpu_held", 32'(cpu_rst_no), 0);
    send_byte(8'h0B);
    chk("a_cpu", 32'(cpu_rst_no), 1);
    chk("a_done", 32'(done_o), 1);
    chk("a_err", 32'(err_o), 0);
    chk("a_busy_end", 32'(busy_o), 0);
    chk("a_nwr", 32'(wr_n - base), 2);
    chk("a_addr0", 32'(wr_addr[base]), 0);
    chk("a_data0", 32'(wr_data[base]), 32'h0105);
    chk("a_addr1", 32'(wr_addr[base+1]), 1);
    chk("a_data1", 32'(wr_data[base+1]), 32'h0203);

    // Reload from RUN, then bad checksum
    send_byte(8'hA5);
    chk("b_cpu_reload", 32'(cpu_rst_no), 0);
    chk("b_done_reload", 32'(done_o), 0);
    chk("b_busy", 32'(busy_o), 1);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h05); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h0C);
    chk("b_err", 32'(err_o), 1);
    chk("b_code", 32'(err_code_o), 2);
    chk("b_ready", 32'(rx_ready_o), 0);
    chk("b_cpu", 32'(cpu_rst_no), 0);
    chk("b_done", 32'(done_o), 0);
    pulse_clear();
    chk("b_clr_err", 32'(err_o), 0);
    chk("b_clr_code", 32'(err_code_o), 0);
    chk("b_clr_ready", 32'(rx_ready_o), 1);
    chk("b_clr_busy", 32'(busy_o), 0);

    // Garbage in IDLE, then bad high byte
    send_byte(8'h00); send_byte(8'h33);
    chk("c_idle_busy", 32'(busy_o), 0);
    base = wr_n;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h80);
    chk("c_err", 32'(err_o), 1);
    chk("c_code", 32'(err_code_o), 1);
    repeat (2) @(posedge clk_i);
    #1;
    chk("c_nwr", 32'(wr_n - base), 0);
    pulse_clear();

    // Timeout after 16 idle cycles
    send_byte(8'hA5);
    chk("d_busy", 32'(busy_o), 1);
    repeat (15) @(posedge clk_i);
    #1;
    chk("d_no_err_yet", 32'(err_o), 0);
    @(posedge clk_i);
    #1;
    chk("d_err", 32'(err_o), 1);
    chk("d_code", 32'(err_code_o), 3);
    pulse_clear();

    // A byte on the 14th cycle restarts the count; a byte on the expiring cycle wins
    base = wr_n;
    send_byte(8'hA5);
    repeat (13) @(posedge clk_i);
    send_byte(8'h01);
    chk("e_no_err_n", 32'(err_o), 0);
    repeat (15) @(posedge clk_i);
    #1;
    chk("e_no_err_hi", 32'(err_o), 0);
    send_byte(8'h01);
    chk("e_no_err_race", 32'(err_o), 0);
    send_byte(8'h02); send_byte(8'h03);
    chk("e_done", 32'(done_o), 1);
    chk("e_nwr", 32'(wr_n - base), 1);
    chk("e_data", 32'(wr_data[base]), 32'h0102);

    // 256-word frame (N = 0) as a reload from RUN
    base = wr_n;
    sum = 8'h00;
    send_byte(8'hA5); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte({1'b0, 7'(i)});
      send_byte(8'(i));
      sum = sum + {1'b0, 7'(i)} + 8'(i);
    end
    chk("f_cpu_held", 32'(cpu_rst_no), 0);
    send_byte(sum);
    chk("f_cpu", 32'(cpu_rst_no), 1);
    chk("f_done", 32'(done_o), 1);
    chk("f_nwr", 32'(wr_n - base), 256);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("f_addr%0d", i), 32'(wr_addr[base+i]), 32'(i));
      chk($sformatf("f_data%0d", i), 32'(wr_data[base+i]), 32'({7'(i), 8'(i)}));
    end
    send_byte(8'h11);
    chk("f_run_garbage", 32'(cpu_rst_no), 1);
    send_byte(8'hA5);
    chk("f_reload_cpu", 32'(cpu_rst_no), 0);
    pulse_clear();

    // Asynchronous reset while a write strobe is up in the middle of a frame
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h05);
    chk("g_we_up", 32'(imem_we_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("g_we", 32'(imem_we_o), 0);
    chk("g_busy", 32'(busy_o), 0);
    chk("g_addr", 32'(imem_addr_o), 0);
    chk("g_data", 32'(imem_data_o), 0);
    chk("g_cpu", 32'(cpu_rst_no), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    base = wr_n;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h01); send_byte(8'h80);
    chk("g_cpu_after", 32'(cpu_rst_no), 1);
    chk("g_nwr", 32'(wr_n - base), 1);
    chk("g_addr_after", 32'(wr_addr[base]), 0);
    chk("g_data_after", 32'(wr_data[base]), 32'h7F01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
